// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU execute unit.
//
// Accepts one {ALUOp, a, b} request at a time and returns a registered
// result. Shifts iterate one bit per cycle; every other op (and undefined
// code 15) completes in a single cycle.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready.
// A result transfers on a rising edge where out_valid & out_ready. in_ready
// is high only in IDLE, out_valid only in DONE, so requests never overlap;
// result/zero/illegal hold until the next result is loaded.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake
//   ALUOp, a, b       operation code and operands (a[4:0] = shift amount,
//                     b = value being shifted)
//   out_valid/out_ready result handshake
//   result, zero      registered result, (result == 0)
//   illegal           accepted op code was undefined
//   dbg_state         current FSM state (IDLE=0, SHIFT=1, DONE=2)
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6,  OP_NOR = 4'd7,  OP_SLT = 4'd8;
  localparam logic [3:0] OP_SLE = 4'd9,  OP_SEQ = 4'd10, OP_SNE = 4'd11;
  localparam logic [3:0] OP_SGT = 4'd12, OP_SGE = 4'd13, OP_SRA = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] work;
  logic [3:0]       op_q;

  logic             accept;
  logic             is_shift;
  logic             multi;
  logic [4:0]       amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic signed [WIDTH-1:0] sa, sb;

  // One-bit shift step for the three shift flavours.
  function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] v);
    case (op)
      OP_SLL:  shift_step = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, v[WIDTH-1:1]};
      default: shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign zero      = (result == '0);

  assign accept   = in_valid & in_ready;
  assign amt      = a[4:0];
  assign is_shift = (ALUOp == OP_SLL) || (ALUOp == OP_SRL) || (ALUOp == OP_SRA);
  // Amounts 0 and 1 finish in the accept cycle; larger amounts iterate.
  assign multi    = is_shift && (amt > 5'd1);
  assign sa       = a;
  assign sb       = b;

  // Single-cycle result computed from the live inputs at acceptance.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUOp)
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLL, OP_SRL, OP_SRA:
        alu_res = (amt == 5'd0) ? b : shift_step(ALUOp, b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (sa <  sb)};
      OP_SLE: alu_res = {{(WIDTH-1){1'b0}}, (sa <= sb)};
      OP_SEQ: alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SNE: alu_res = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_SGT: alu_res = {{(WIDTH-1){1'b0}}, (sa >  sb)};
      OP_SGE: alu_res = {{(WIDTH-1){1'b0}}, (sa >= sb)};
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = multi ? SHIFT : DONE;
      SHIFT:   if (cnt == 5'd1) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath. The accept edge already performs the first shift step, so
  // SHIFT runs amt-1 cycles and a shift by N reports out_valid N cycles
  // after acceptance, the same cadence as a single-cycle op for N = 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      work    <= '0;
      op_q    <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= ALUOp;
            if (multi) begin
              work <= shift_step(ALUOp, b);
              cnt  <= amt - 5'd1;
            end else begin
              result  <= alu_res;
              illegal <= alu_ill;
            end
          end
        end
        SHIFT: begin
          work <= shift_step(op_q, work);
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result  <= shift_step(op_q, work);
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed self-checking bench for alu_seq_exec.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int lat;

  // Clock / reset
  always #5 clk = ~clk;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(alu_op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  // Driver: present a request (called #1 after an edge, unit idle), then
  // scramble the operands and count cycles until out_valid is seen.
  task automatic send_op(input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, output int latency);
    alu_op = op; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; alu_op = 4'd1;
    latency = 1;
    while (!out_valid && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  // Driver: take the pending result.
  task automatic complete;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    send_op(4'd0, 32'hFFFF_FFFF, 32'h1, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_result: got %h want 00000000", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL add_zero: got %b want 1", zero); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b want 0", illegal); end
    complete();
  endtask

  task automatic test_shifts;
    send_op(4'd5, 32'd31, 32'h1, lat);
    checks++; if (lat !== 31) begin errors++; $display("FAIL sll31_latency: got %0d want 31", lat); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result: got %h want 80000000", result); end
    complete();
    send_op(4'd14, 32'd4, 32'h8000_0000, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sra4_latency: got %0d want 4", lat); end
    checks++; if (result !== 32'hF800_0000) begin errors++; $display("FAIL sra4_result: got %h want f8000000", result); end
    complete();
    send_op(4'd6, 32'd0, 32'hF0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL srl0_latency: got %0d want 1", lat); end
    checks++; if (result !== 32'hF0) begin errors++; $display("FAIL srl0_result: got %h want 000000f0", result); end
    complete();
    send_op(4'd6, 32'd1, 32'hF0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL srl1_latency: got %0d want 1", lat); end
    checks++; if (result !== 32'h78) begin errors++; $display("FAIL srl1_result: got %h want 00000078", result); end
    complete();
    send_op(4'd6, 32'd3, 32'h8000_0000, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL srl3_latency: got %0d want 3", lat); end
    checks++; if (result !== 32'h1000_0000) begin errors++; $display("FAIL srl3_result: got %h want 10000000", result); end
    complete();
  endtask

  task automatic test_compares;
    send_op(4'd8, 32'hFFFF_FFFF, 32'h1, lat);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL slt_result: got %h want 00000001", result); end
    complete();
    send_op(4'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL sgt_result: got %h want 00000001", result); end
    complete();
    send_op(4'd13, 32'h0, 32'h0, lat);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL sge_result: got %h want 00000001", result); end
    complete();
    send_op(4'd11, 32'd5, 32'd5, lat);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sne_result: got %h want 00000000", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sne_zero: got %b want 1", zero); end
    complete();
    send_op(4'd9, 32'd2, 32'd1, lat);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL sle_result: got %h want 00000000", result); end
    complete();
    send_op(4'd7, 32'h0000_FFFF, 32'hFF00_0000, lat);
    checks++; if (result !== 32'h00FF_0000) begin errors++; $display("FAIL nor_result: got %h want 00ff0000", result); end
    complete();
  endtask

  task automatic test_backpressure;
    send_op(4'd4, 32'h0000_F0F0, 32'h0000_FF00, lat);
    checks++; if (result !== 32'h0000_0FF0) begin errors++; $display("FAIL bp_result: got %h want 00000ff0", result); end
    alu_op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== 32'h0000_0FF0) begin errors++; $display("FAIL bp_hold_result: got %h want 00000ff0", result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    end
    in_valid = 1'b0;
    complete();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_return: got %b want 1", in_ready); end
    checks++; if (result !== 32'h0000_0FF0) begin errors++; $display("FAIL bp_after_result: got %h want 00000ff0", result); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal;
    send_op(4'd15, 32'd3, 32'd4, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ill_latency: got %0d want 1", lat); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", illegal); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL ill_result: got %h want 00000000", result); end
    complete();
    send_op(4'd0, 32'd2, 32'd3, lat);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL add_after_ill_flag: got %b want 0", illegal); end
    checks++; if (result !== 32'd5) begin errors++; $display("FAIL add_after_ill_result: got %h want 00000005", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_after_ill_zero: got %b want 0", zero); end
    complete();
  endtask

  task automatic test_reset_mid_shift;
    alu_op = 4'd5; a = 32'd20; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_shift_state: got %0d want 1", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mid_rst_result: got %h want 00000000", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_result: got %b want 0", out_valid); end
    send_op(4'd2, 32'h0000_FF00, 32'h0000_0FF0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL and_latency: got %0d want 1", lat); end
    checks++; if (result !== 32'h0000_0F00) begin errors++; $display("FAIL and_result: got %h want 00000f00", result); end
    complete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shifts();
    test_compares();
    test_backpressure();
    test_illegal();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
